regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file with a write-forwarding bypass and a per-register busy scoreboard.
- After reset, a sweep state machine clears the storage array one register per cycle.
- It is the next-generation regfile for the dual-writeback core: it serves NRD read ports from decode/issue and two writeback ports (W0 older, W1 younger).
- Register 0 is hardwired to zero.

Parameters:
- XLEN, 64, data width of each register.
- NREG, 32, number of registers; a power of two, at least 2.
- AW, 5, register address width; AW equals log2(NREG).
- NRD, 2, number of read ports; range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ready_o  out  1  high when the block is in RUN.
- re_i  in  NRD  per-port read enable.
- raddr_i  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rdata_o  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- rbusy_o  out  NRD  per-port: the addressed register has an outstanding producer.
- we0_i  in  1  write-port 0 enable (older instruction).
- waddr0_i  in  AW  write-port 0 address.
- wdata0_i  in  XLEN  write-port 0 data.
- we1_i  in  1  write-port 1 enable (younger instruction).
- waddr1_i  in  AW  write-port 1 address.
- wdata1_i  in  XLEN  write-port 1 data.
- iss_i  in  1  issue strobe: mark a destination register busy.
- iss_addr_i  in  AW  destination register being issued.

Behaviour:
- Reset: while rst=1 the state is CLEAR, sweep counter = 0, all busy bits = 0, ready_o = 0. All rdata_o = 0 and all rbusy_o = 0 (combinationally forced by rst).
- CLEAR state:
  - Each cycle, regs[cnt] <= 0 and cnt increments.
  - When cnt = NREG-1, that register is written and the next state is RUN.
  - CLEAR therefore lasts exactly NREG cycles after rst falls; ready_o rises on cycle NREG.
  - During CLEAR, write ports and iss_i are ignored, rdata_o = 0, rbusy_o = 0.
- RUN state: remains until rst. rst asserted mid-operation returns to CLEAR, clears all busy bits, and re-sweeps the array.
- Writes (RUN only, at the clock edge):
  - A write port with enable set and a nonzero address writes its data.
  - Both ports to the same nonzero address: W1 data is stored.
  - Address 0 writes are discarded.
- Reads (combinational, zero latency), priority per port k:
  - rst=1, or not RUN, or re_i[k]=0, or address 0: output 0.
  - else we1_i and waddr1_i match: wdata1_i.
  - else we0_i and waddr0_i match: wdata0_i.
  - else regs[addr].
- Scoreboard:
  - busy[NREG] flops; busy[0] is constantly 0.
  - At the edge in RUN, a write on either port to address a (nonzero) clears busy[a].
  - iss_i with nonzero iss_addr_i sets busy[iss_addr_i].
  - Set and clear of the same address in one cycle: set wins, because the new producer supersedes the completing one.
  - iss_addr_i = 0 has no effect.
- rbusy_o[k] = RUN and re_i[k] and busy[raddr_k] and not (a write port writes raddr_k this cycle). A value being forwarded is never reported busy.
- No output is registered except ready_o; rdata_o and rbusy_o are purely combinational from inputs and state.

Test Plan:
- Reset sweep: hold rst 3 cycles, release with we0=1, addr 5, data 0xAA, and iss_i to addr 5 during CLEAR -> ready_o=0 for 32 cycles then 1; regs[5] reads 0; rbusy for addr 5 = 0; all 32 registers read 0.
- Write/readback: in RUN, W0 writes 0x1234_5678_9ABC_DEF0 to x7 -> next cycle port0 reading x7 returns that value; a W0 write to x0 with 0xFFFF -> x0 reads 0.
- Bypass priority: same cycle, W0 writes 0x11 to x3, W1 writes 0x22 to x3, both read ports on x3 -> both return 0x22 combinationally; next cycle stored value is 0x22.
- Scoreboard: issue x9 -> rbusy=1 from next cycle; W0 writes 0x55 to x9 -> rbusy=0 that cycle with rdata=0x55; busy clear afterwards. Issue x9 and write x9 in the same cycle -> busy stays 1.
- Read enable: re_i[1]=0 on a written x4 -> rdata port1 = 0 and rbusy port1 = 0.
- Mid-run reset: registers x1..x31 hold nonzero values, several busy bits set; pulse rst 1 cycle -> ready_o low for 32 cycles, then all reads 0 and no busy bits set.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port integer register file with write-forwarding bypass
// and a per-register busy scoreboard.
//
// After reset a sweep state machine clears the storage one register per cycle
// (CLEAR, NREG cycles), then the block sits in RUN until the next reset.
// Register 0 always reads as zero and is never busy.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   ready_o      high while in RUN (registered)
//   re_i         per-port read enable [NRD]
//   raddr_i      read addresses, port k at [k*AW +: AW]
//   rdata_o      read data, port k at [k*XLEN +: XLEN] (combinational)
//   rbusy_o      per-port: addressed register has an outstanding producer
//   we0_i/waddr0_i/wdata0_i   write port 0 (older instruction)
//   we1_i/waddr1_i/wdata1_i   write port 1 (younger instruction)
//   iss_i/iss_addr_i          issue strobe: mark a destination busy
module regfile_mp #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int NRD  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ready_o,
   input  logic [NRD-1:0]        re_i,
   input  logic [NRD*AW-1:0]     raddr_i,
   output logic [NRD*XLEN-1:0]   rdata_o,
   output logic [NRD-1:0]        rbusy_o,
   input  logic                  we0_i,
   input  logic [AW-1:0]         waddr0_i,
   input  logic [XLEN-1:0]       wdata0_i,
   input  logic                  we1_i,
   input  logic [AW-1:0]         waddr1_i,
   input  logic [XLEN-1:0]       wdata1_i,
   input  logic                  iss_i,
   input  logic [AW-1:0]         iss_addr_i
);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t            state_q;
   logic [AW-1:0]     cnt_q;
   logic              ready_q;
   logic [NREG-1:0]   busy_q;
   logic [NREG-1:0]   busy_d;
   logic [XLEN-1:0]   regs_q [NREG];

   logic              run;
   logic              wr0_en;
   logic              wr1_en;
   logic              iss_en;

   assign run     = (state_q == S_RUN);
   // Effective writes: RUN only, address 0 is discarded.
   assign wr0_en  = run && we0_i && (waddr0_i != '0);
   assign wr1_en  = run && we1_i && (waddr1_i != '0);
   assign iss_en  = run && iss_i && (iss_addr_i != '0);
   assign ready_o = ready_q;

   // Sweep / run state machine with registered ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            S_CLEAR: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == AW'(NREG - 1)) begin
                  state_q <= S_RUN;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= S_RUN;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Storage. No reset here: the sweep clears contents after reset.
   // W1 is written last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == S_CLEAR) begin
            regs_q[cnt_q] <= '0;
         end else begin
            if (wr0_en) regs_q[waddr0_i] <= wdata0_i;
            if (wr1_en) regs_q[waddr1_i] <= wdata1_i;
         end
      end
   end

   // Scoreboard next state: completions clear, then issue sets, so a new
   // producer supersedes one completing in the same cycle.
   always_comb begin
      busy_d = busy_q;
      if (wr0_en) busy_d[waddr0_i] = 1'b0;
      if (wr1_en) busy_d[waddr1_i] = 1'b0;
      if (iss_en) busy_d[iss_addr_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   // Read ports: zero latency, W1 forwarding beats W0 beats storage.
   generate
      for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
         logic [AW-1:0]   ra;
         logic            act;
         logic            hit0;
         logic            hit1;
         logic [XLEN-1:0] rd;

         assign ra   = raddr_i[gi*AW +: AW];
         assign act  = !rst && run && re_i[gi] && (ra != '0);
         assign hit1 = wr1_en && (waddr1_i == ra);
         assign hit0 = wr0_en && (waddr0_i == ra);

         always_comb begin
            rd = '0;
            if (act) begin
               if (hit1)      rd = wdata1_i;
               else if (hit0) rd = wdata0_i;
               else           rd = regs_q[ra];
            end
         end

         assign rdata_o[gi*XLEN +: XLEN] = rd;
         // A value being forwarded this cycle is never reported busy.
         assign rbusy_o[gi] = act && busy_q[ra] && !hit0 && !hit1;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- directed, table-driven bench for regfile_mp (default
// parameters: XLEN=64, NREG=32, AW=5, NRD=2) plus hand-written sequences for
// the reset sweep and the mid-run reset.
module tb_regfile_mp;

   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int NRD  = 2;

   logic                clk;
   logic                rst;
   logic                ready_o;
   logic [NRD-1:0]      re_i;
   logic [AW-1:0]       ra0, ra1;
   logic [NRD*XLEN-1:0] rdata_o;
   logic [NRD-1:0]      rbusy_o;
   logic                we0_i, we1_i, iss_i;
   logic [AW-1:0]       waddr0_i, waddr1_i, iss_addr_i;
   logic [XLEN-1:0]     wdata0_i, wdata1_i;

   int checks = 0;
   int errors = 0;

   regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD)) dut (
      .clk        (clk),
      .rst        (rst),
      .ready_o    (ready_o),
      .re_i       (re_i),
      .raddr_i    ({ra1, ra0}),
      .rdata_o    (rdata_o),
      .rbusy_o    (rbusy_o),
      .we0_i      (we0_i),
      .waddr0_i   (waddr0_i),
      .wdata0_i   (wdata0_i),
      .we1_i      (we1_i),
      .waddr1_i   (waddr1_i),
      .wdata1_i   (wdata1_i),
      .iss_i      (iss_i),
      .iss_addr_i (iss_addr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  re;
      logic [4:0]  ra0, ra1;
      logic        we0;
      logic [4:0]  wa0;
      logic [63:0] wd0;
      logic        we1;
      logic [4:0]  wa1;
      logic [63:0] wd1;
      logic        iss;
      logic [4:0]  ia;
      logic [63:0] e0, e1;
      logic [1:0]  eb;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                      input logic w0, input logic [4:0] wa0, input logic [63:0] wd0,
                      input logic w1, input logic [4:0] wa1, input logic [63:0] wd1,
                      input logic is, input logic [4:0] ia,
                      input logic [63:0] e0, input logic [63:0] e1, input logic [1:0] eb);
      vec_t v;
      v.re = re; v.ra0 = a0; v.ra1 = a1;
      v.we0 = w0; v.wa0 = wa0; v.wd0 = wd0;
      v.we1 = w1; v.wa1 = wa1; v.wd1 = wd1;
      v.iss = is; v.ia = ia;
      v.e0 = e0; v.e1 = e1; v.eb = eb;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      re_i = '0; ra0 = '0; ra1 = '0;
      we0_i = 1'b0; waddr0_i = '0; wdata0_i = '0;
      we1_i = 1'b0; waddr1_i = '0; wdata1_i = '0;
      iss_i = 1'b0; iss_addr_i = '0;
   endtask

   // Called right after rst has been dropped at a falling edge: expects
   // exactly NREG rising edges with ready low, then ready high.
   task automatic sweep_wait(input string tag);
      for (int c = 0; c < NREG; c++) begin
         #1;
         chk({tag, "_ready_low"}, 64'(ready_o), 64'd0);
         chk({tag, "_clear_rdata"}, rdata_o[63:0], 64'd0);
         chk({tag, "_clear_rbusy"}, 64'(rbusy_o), 64'd0);
         @(negedge clk);
      end
      idle();
      #1;
      chk({tag, "_ready_high"}, 64'(ready_o), 64'd1);
      $display("%s: sweep finished, ready_o=%0d", tag, ready_o);
   endtask

   task automatic read_all_zero(input string tag);
      for (int i = 0; i < NREG; i++) begin
         @(negedge clk);
         idle();
         re_i = 2'b11; ra0 = AW'(i); ra1 = AW'(NREG - 1 - i);
         #1;
         chk({tag, "_rd0"}, rdata_o[63:0], 64'd0);
         chk({tag, "_rd1"}, rdata_o[127:64], 64'd0);
         chk({tag, "_rbusy"}, 64'(rbusy_o), 64'd0);
      end
      $display("%s: all %0d registers read back", tag, NREG);
   endtask

   initial begin
      //   re    ra0 ra1 we0 wa0 wd0                    we1 wa1 wd1     iss ia   e0                     e1                     eb
      add(2'b01, 7, 0, 1, 7, 64'h1234_5678_9ABC_DEF0, 0, 0, 64'h0,   0, 0,  64'h1234_5678_9ABC_DEF0, 64'h0,                 2'b00);
      add(2'b11, 7, 0, 1, 0, 64'hFFFF,               0, 0, 64'h0,   0, 0,  64'h1234_5678_9ABC_DEF0, 64'h0,                 2'b00);
      add(2'b11, 0, 7, 0, 0, 64'h0,                  0, 0, 64'h0,   0, 0,  64'h0,                   64'h1234_5678_9ABC_DEF0, 2'b00);
      add(2'b11, 3, 3, 1, 3, 64'h11,                 1, 3, 64'h22,  0, 0,  64'h22,                  64'h22,                 2'b00);
      add(2'b11, 3, 3, 0, 0, 64'h0,                  0, 0, 64'h0,   0, 0,  64'h22,                  64'h22,                 2'b00);
      add(2'b01, 9, 0, 0, 0, 64'h0,                  0, 0, 64'h0,   1, 9,  64'h0,                   64'h0,                  2'b00);
      add(2'b01, 9, 0, 0, 0, 64'h0,                  0, 0, 64'h0,   0, 0,  64'h0,                   64'h0,                  2'b01);
      add(2'b11, 9, 9, 1, 9, 64'h55,                 0, 0, 64'h0,   0, 0,  64'h55,                  64'h55,                 2'b00);
      add(2'b11, 9, 9, 0, 0, 64'h0,                  0, 0, 64'h0,   0, 0,  64'h55,                  64'h55,                 2'b00);
      add(2'b01, 9, 0, 0, 0, 64'h0,                  1, 9, 64'h66,  1, 9,  64'h66,                  64'h0,                  2'b00);
      add(2'b11, 9, 9, 0, 0, 64'h0,                  0, 0, 64'h0,   0, 0,  64'h66,                  64'h66,                 2'b11);
      add(2'b00, 4, 4, 1, 4, 64'h44,                 0, 0, 64'h0,   0, 0,  64'h0,                   64'h0,                  2'b00);
      add(2'b01, 4, 4, 0, 0, 64'h0,                  0, 0, 64'h0,   1, 4,  64'h44,                  64'h0,                  2'b00);
      add(2'b01, 4, 4, 0, 0, 64'h0,                  0, 0, 64'h0,   0, 0,  64'h44,                  64'h0,                  2'b01);
      add(2'b11, 10, 11, 1, 10, 64'hA0,              1, 11, 64'hB1, 0, 0,  64'hA0,                  64'hB1,                 2'b00);
      add(2'b11, 11, 10, 0, 0, 64'h0,                0, 0, 64'h0,   0, 0,  64'hB1,                  64'hA0,                 2'b00);
      add(2'b11, 9, 4, 0, 0, 64'h0,                  1, 9, 64'h77,  0, 0,  64'h77,                  64'h44,                 2'b10);
      add(2'b11, 9, 9, 0, 0, 64'h0,                  0, 0, 64'h0,   0, 0,  64'h77,                  64'h77,                 2'b00);
      add(2'b11, 0, 0, 0, 0, 64'h0,                  0, 0, 64'h0,   1, 0,  64'h0,                   64'h0,                  2'b00);
      add(2'b11, 4, 5, 1, 4, 64'h45,                 1, 5, 64'h50,  0, 0,  64'h45,                  64'h50,                 2'b00);
      add(2'b11, 4, 5, 0, 0, 64'h0,                  0, 0, 64'h0,   0, 0,  64'h45,                  64'h50,                 2'b00);

      // ---- reset sweep ----
      idle();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      re_i = 2'b11; ra0 = 5'd3; ra1 = 5'd3;
      we1_i = 1'b1; waddr1_i = 5'd3; wdata1_i = 64'h99;
      #1;
      chk("rst_rdata_forced", rdata_o[63:0], 64'd0);
      chk("rst_rbusy_forced", 64'(rbusy_o), 64'd0);
      chk("rst_ready", 64'(ready_o), 64'd0);
      rst = 1'b0;
      idle();
      re_i = 2'b11; ra0 = 5'd5; ra1 = 5'd5;
      we0_i = 1'b1; waddr0_i = 5'd5; wdata0_i = 64'hAA;
      iss_i = 1'b1; iss_addr_i = 5'd5;
      sweep_wait("init");
      re_i = 2'b01; ra0 = 5'd5;
      #1;
      chk("init_x5_data", rdata_o[63:0], 64'd0);
      chk("init_x5_busy", 64'(rbusy_o), 64'd0);
      read_all_zero("init");

      // ---- vector table ----
      foreach (vecs[n]) begin
         @(negedge clk);
         re_i = vecs[n].re; ra0 = vecs[n].ra0; ra1 = vecs[n].ra1;
         we0_i = vecs[n].we0; waddr0_i = vecs[n].wa0; wdata0_i = vecs[n].wd0;
         we1_i = vecs[n].we1; waddr1_i = vecs[n].wa1; wdata1_i = vecs[n].wd1;
         iss_i = vecs[n].iss; iss_addr_i = vecs[n].ia;
         #1;
         chk($sformatf("vec%0d_rdata0", n), rdata_o[63:0], vecs[n].e0);
         chk($sformatf("vec%0d_rdata1", n), rdata_o[127:64], vecs[n].e1);
         chk($sformatf("vec%0d_rbusy", n), 64'(rbusy_o), 64'(vecs[n].eb));
         chk($sformatf("vec%0d_ready", n), 64'(ready_o), 64'd1);
         $display("vec %0d: rdata0=%h rdata1=%h rbusy=%b", n, rdata_o[63:0], rdata_o[127:64], rbusy_o);
      end

      // ---- mid-run reset ----
      for (int i = 1; i < NREG; i++) begin
         @(negedge clk);
         idle();
         we0_i = 1'b1; waddr0_i = AW'(i); wdata0_i = 64'h0101_0101_0000_0000 | 64'(i);
         if (i == 2 || i == 8 || i == 20) begin
            iss_i = 1'b1; iss_addr_i = AW'(i);
         end
      end
      @(negedge clk);
      idle();
      re_i = 2'b11; ra0 = 5'd8; ra1 = 5'd31;
      #1;
      chk("pre_rst_x8", rdata_o[63:0], 64'h0101_0101_0000_0008);
      chk("pre_rst_x31", rdata_o[127:64], 64'h0101_0101_0000_001F);
      chk("pre_rst_busy", 64'(rbusy_o), 64'd1);
      $display("mid-run: x1..x31 loaded, x2/x8/x20 busy");
      @(negedge clk);
      rst = 1'b1;
      re_i = 2'b11; ra0 = 5'd8; ra1 = 5'd20;
      #1;
      chk("midrst_rdata", rdata_o[63:0], 64'd0);
      chk("midrst_rbusy", 64'(rbusy_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      sweep_wait("midrst");
      read_all_zero("midrst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
